// File: rtl/mux_n_1_rr_if.sv
// Handshake bundle for mux_n_1_rr: N producer channels in, one registered consumer channel out.
// The mux itself uses the slave modport; the environment driving it uses master.
interface mux_n_1_rr_if #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = $clog2(N)
);
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [SELW-1:0] sel;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic [SELW-1:0] out_src;

   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );

   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_valid, out_src
   );
endinterface

// File: rtl/mux_n_1_rr.sv
// N:1 W-bit handshake mux with a single-entry output register; external select (RR=0) or round-robin (RR=1).
// Define MUX_N_1_RR_STATS_EN to add the xfer_cnt / stall_cnt statistics ports.
module mux_n_1_rr #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int RR   = 0,
   parameter int SELW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   mux_n_1_rr_if.slave  bus
`ifdef MUX_N_1_RR_STATS_EN
   ,
   output logic [31:0]  xfer_cnt,
   output logic [31:0]  stall_cnt
`endif
);

   logic            out_valid_q;
   logic [W-1:0]    out_data_q;
   logic [SELW-1:0] out_src_q;

   logic            space;
   logic            gnt_vld;
   logic [SELW-1:0] gnt_idx;
   logic [N-1:0]    gnt_oh;
   logic [N-1:0]    in_ready_c;
   logic [W-1:0]    mux_data;
   logic            accept;

   assign space = !out_valid_q || bus.out_ready;

   generate
      if (RR != 0) begin : g_rr
         logic [SELW-1:0] ptr_q;
         logic            unused_sel;

         assign unused_sel = ^bus.sel;

         // Pick the lowest valid channel at or above ptr; failing that, wrap to the lowest valid overall.
         always_comb begin
            logic            lo_any, hi_any;
            logic [SELW-1:0] lo_idx, hi_idx;
            // NOTE: every comb output gets a default before any branch, otherwise a latch is inferred.
            lo_any = 1'b0;
            hi_any = 1'b0;
            lo_idx = '0;
            hi_idx = '0;
            for (int i = N - 1; i >= 0; i--) begin
               if (bus.in_valid[i]) begin
                  lo_any = 1'b1;
                  lo_idx = SELW'(i);
               end
               if (bus.in_valid[i] && i >= int'(ptr_q)) begin
                  hi_any = 1'b1;
                  hi_idx = SELW'(i);
               end
            end
            gnt_vld = lo_any;
            gnt_idx = hi_any ? hi_idx : lo_idx;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               ptr_q <= '0;
            end else if (accept) begin
               ptr_q <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
            end
         end
      end else begin : g_ext
         always_comb begin
            gnt_vld = int'(bus.sel) < N;
            gnt_idx = bus.sel;
         end
      end
   endgenerate

   always_comb begin
      gnt_oh = '0;
      for (int i = 0; i < N; i++) begin
         gnt_oh[i] = gnt_vld && (gnt_idx == SELW'(i));
      end
   end

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N; i++) begin
         // NOTE: blocking assignments in comb logic let the OR accumulate within one evaluation.
         if (gnt_oh[i]) mux_data = mux_data | bus.in_data[i*W +: W];
      end
   end

   // No channel is offered ready while reset is asserted, so a reset cycle never accepts.
   assign in_ready_c   = (space && !rst) ? gnt_oh : '0;
   assign accept       = |(in_ready_c & bus.in_valid);
   assign bus.in_ready = in_ready_c;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= mux_data;
         out_src_q   <= gnt_idx;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;

`ifdef MUX_N_1_RR_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (out_valid_q && bus.out_ready)  xfer_cnt  <= xfer_cnt + 32'd1;
         if (out_valid_q && !bus.out_ready) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Bench for mux_n_1_rr: an external-select instance (N=6) and a round-robin instance (N=4)
// run in lockstep against a queue-based reference model, with directed scenarios then random traffic.
module tb_mux_n_1_rr;
   localparam int NE = 6;
   localparam int NR = 4;
   localparam int W  = 8;

   logic clk;
   logic rst;

   mux_n_1_rr_if #(.N(NE), .W(W)) bus_e ();
   mux_n_1_rr_if #(.N(NR), .W(W)) bus_r ();

`ifdef MUX_N_1_RR_STATS_EN
   logic [31:0] e_xfer, e_stall, r_xfer, r_stall;
   logic [31:0] e_xc, e_sc, r_xc, r_sc;
`endif

   mux_n_1_rr #(.N(NE), .W(W), .RR(0)) u_ext (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_e)
`ifdef MUX_N_1_RR_STATS_EN
      ,
      .xfer_cnt  (e_xfer),
      .stall_cnt (e_stall)
`endif
   );

   mux_n_1_rr #(.N(NR), .W(W), .RR(1)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_r)
`ifdef MUX_N_1_RR_STATS_EN
      ,
      .xfer_cnt  (r_xfer),
      .stall_cnt (r_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: one output slot per instance, plus the round-robin priority order.
   bit          e_mv, r_mv;
   logic [W-1:0] e_md, r_md;
   int          e_ms, r_ms;
   int          rr_order[$];
   logic [NR-1:0] last_ready_r;
   logic [NE-1:0] last_ready_e;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      e_mv = 1'b0; e_md = '0; e_ms = 0;
      r_mv = 1'b0; r_md = '0; r_ms = 0;
      rr_order = {};
      for (int i = 0; i < NR; i++) rr_order.push_back(i);
`ifdef MUX_N_1_RR_STATS_EN
      e_xc = '0; e_sc = '0; r_xc = '0; r_sc = '0;
`endif
   endtask

   // One clock: check comb ready, advance the model at the edge, check registered outputs.
   task automatic step();
      int ge, gr, x;
      bit sp_e, sp_r;
      logic [NE-1:0] exp_re;
      logic [NR-1:0] exp_rr;
      #1;
      ge = (int'(bus_e.sel) < NE) ? int'(bus_e.sel) : -1;
      gr = -1;
      foreach (rr_order[k]) if (gr < 0 && bus_r.in_valid[rr_order[k]]) gr = rr_order[k];
      sp_e = !e_mv || bus_e.out_ready;
      sp_r = !r_mv || bus_r.out_ready;
      exp_re = (!rst && ge >= 0 && sp_e) ? (NE'(1) << ge) : '0;
      exp_rr = (!rst && gr >= 0 && sp_r) ? (NR'(1) << gr) : '0;
      last_ready_e = bus_e.in_ready;
      last_ready_r = bus_r.in_ready;
      check("ext_in_ready", bus_e.in_ready, exp_re);
      check("rr_in_ready", bus_r.in_ready, exp_rr);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
`ifdef MUX_N_1_RR_STATS_EN
         if (e_mv && bus_e.out_ready)  e_xc++;
         if (e_mv && !bus_e.out_ready) e_sc++;
         if (r_mv && bus_r.out_ready)  r_xc++;
         if (r_mv && !bus_r.out_ready) r_sc++;
`endif
         if (ge >= 0 && bus_e.in_valid[ge] && sp_e) begin
            e_mv = 1'b1; e_md = bus_e.in_data[ge*W +: W]; e_ms = ge;
         end else if (bus_e.out_ready) begin
            e_mv = 1'b0;
         end
         if (gr >= 0 && sp_r) begin
            r_mv = 1'b1; r_md = bus_r.in_data[gr*W +: W]; r_ms = gr;
            // The granted channel drops to lowest priority.
            do begin
               x = rr_order.pop_front();
               rr_order.push_back(x);
            end while (x != gr);
         end else if (bus_r.out_ready) begin
            r_mv = 1'b0;
         end
      end
      @(negedge clk);
      check("ext_out_valid", bus_e.out_valid, e_mv);
      check("ext_out_data", bus_e.out_data, e_md);
      check("ext_out_src", bus_e.out_src, e_ms);
      check("rr_out_valid", bus_r.out_valid, r_mv);
      check("rr_out_data", bus_r.out_data, r_md);
      check("rr_out_src", bus_r.out_src, r_ms);
`ifdef MUX_N_1_RR_STATS_EN
      check("ext_xfer_cnt", e_xfer, e_xc);
      check("ext_stall_cnt", e_stall, e_sc);
      check("rr_xfer_cnt", r_xfer, r_xc);
      check("rr_stall_cnt", r_stall, r_sc);
`endif
   endtask

   task automatic rr_all_valid();
      bus_r.in_valid = '1;
      bus_r.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
   endtask

   initial begin
      model_reset();
      rst             = 1'b1;
      bus_e.in_data   = '0;
      bus_e.in_valid  = '1;
      bus_e.sel       = '0;
      bus_e.out_ready = 1'b1;
      bus_r.sel       = '0;
      bus_r.out_ready = 1'b1;
      rr_all_valid();

      // Reset held two cycles with every channel valid.
      step();
      step();
      check("rst_out_valid", bus_r.out_valid, 0);
      check("rst_out_data", bus_r.out_data, 8'h00);
      check("rst_in_ready", last_ready_r, 0);
      check("rst_ext_in_ready", last_ready_e, 0);

      // Round-robin rotation with all channels valid.
      rst = 1'b0;
      bus_e.in_valid = '0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k == 0) check("rr_first_grant", last_ready_r, 4'b0001);
         check("rr_seq_data", bus_r.out_data, 8'h10 + 8'(k % NR));
         check("rr_seq_valid", bus_r.out_valid, 1);
      end

      // External select, including out-of-range selects on the N=6 instance.
      bus_r.in_valid  = '0;
      bus_e.in_data   = 48'hA5 << (2 * W);
      bus_e.in_valid  = 6'b000100;
      bus_e.sel       = 3'd2;
      step();
      check("ext_sel2_ready", last_ready_e, 6'b000100);
      check("ext_sel2_data", bus_e.out_data, 8'hA5);
      check("ext_sel2_src", bus_e.out_src, 2);
      bus_e.in_data   = 48'h5B << (5 * W);
      bus_e.in_valid  = 6'b100000;
      bus_e.sel       = 3'd5;
      step();
      check("ext_sel5_src", bus_e.out_src, 5);
      check("ext_sel5_data", bus_e.out_data, 8'h5B);
      bus_e.in_valid  = '1;
      for (int s = 6; s < 8; s++) begin
         bus_e.sel = 3'(s);
         step();
         check("ext_oor_ready", last_ready_e, 0);
         check("ext_oor_valid", bus_e.out_valid, 0);
      end
      bus_e.in_valid = '0;

      // Sparse valids: grants alternate 1,3 then stay on 1 without a bubble.
      rr_all_valid();
      bus_r.in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         step();
         check("rr_sparse_src", bus_r.out_src, (k % 2 == 0) ? 1 : 3);
      end
      bus_r.in_valid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rr_single_src", bus_r.out_src, 1);
         check("rr_single_valid", bus_r.out_valid, 1);
      end

      // Backpressure holds 0x3C; releasing it lets 0x77 follow with no bubble.
      bus_r.in_valid = 4'b0001;
      bus_r.in_data  = 32'h3C;
      step();
      check("bp_load", bus_r.out_data, 8'h3C);
      bus_r.in_data   = 32'h77;
      bus_r.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_hold_data", bus_r.out_data, 8'h3C);
         check("bp_hold_ready", last_ready_r, 0);
      end
      bus_r.out_ready = 1'b1;
      step();
      check("bp_release_ready", last_ready_r, 4'b0001);
      check("bp_release_data", bus_r.out_data, 8'h77);
      check("bp_release_valid", bus_r.out_valid, 1);

      // Reset mid-stream with the pointer advanced; first grant afterwards is ch0 again.
      rr_all_valid();
      step();
      check("mid_src", bus_r.out_src, 1);
      rst = 1'b1;
      step();
      check("mid_rst_valid", bus_r.out_valid, 0);
      check("mid_rst_ready", last_ready_r, 0);
      rst = 1'b0;
      step();
      check("mid_post_src", bus_r.out_src, 0);
      for (int k = 0; k < 6; k++) step();
      bus_r.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) step();
`ifdef MUX_N_1_RR_STATS_EN
      check("stats_xfer", r_xfer, 6);
      check("stats_stall", r_stall, 3);
`endif
      rst = 1'b1;
      step();
`ifdef MUX_N_1_RR_STATS_EN
      check("stats_xfer_rst", r_xfer, 0);
      check("stats_stall_rst", r_stall, 0);
`endif
      rst = 1'b0;
      bus_r.out_ready = 1'b1;

      // Random traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         rst             = ($urandom_range(0, 49) == 0);
         bus_e.in_data   = 48'({$urandom(), $urandom()});
         bus_e.in_valid  = NE'($urandom());
         bus_e.sel       = 3'($urandom_range(0, 7));
         bus_e.out_ready = ($urandom_range(0, 3) != 0);
         bus_r.in_data   = 32'($urandom());
         bus_r.in_valid  = NR'($urandom());
         bus_r.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
